bp_branch_event_buffer: RTL and testbench

Monitor stage upstream of the branch profiler. It taps the BE→FE command handshake and classifies every accepted attaboy or branch-mispredict redirect into a compact branch event record. Each record is stamped with the committed-instruction count and queued in a small FIFO. A downstream profiler or trace writer drains the FIFO with a valid/yumi handshake, so the stats and CSV writer never has to decode `fe_cmd` itself.

---
 rtl/bp_branch_event_buffer_pkg.sv | 89 ++++++++
 rtl/bp_branch_event_buffer_fifo.sv | 49 ++++
 rtl/bp_branch_event_buffer.sv | 118 +++++++++++
 tb/tb_bp_branch_event_buffer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_branch_event_buffer_pkg.sv
// Types shared by the branch event buffer: FE command layout, branch type enum and record width.
package bp_branch_event_buffer_pkg;

  typedef enum logic {e_bp_default_cfg} bp_params_e;

  localparam int unsigned vaddr_width_gp = 39;

  typedef enum logic [2:0] {
    e_br_type_br      = 3'd0,
    e_br_type_jal     = 3'd1,
    e_br_type_jalr    = 3'd2,
    e_br_type_call    = 3'd3,
    e_br_type_ret     = 3'd4,
    e_br_type_unknown = 3'd5
  } bp_branch_type_e;

  typedef enum logic [2:0] {
    e_op_state_reset          = 3'd0,
    e_op_pc_redirection       = 3'd1,
    e_op_icache_fill_response = 3'd2,
    e_op_icache_fence         = 3'd3,
    e_op_attaboy              = 3'd4,
    e_op_wait                 = 3'd5
  } bp_fe_command_queue_opcodes_e;

  typedef enum logic [2:0] {
    e_subop_branch_mispredict  = 3'd0,
    e_subop_trap               = 3'd1,
    e_subop_eret               = 3'd2,
    e_subop_interrupt          = 3'd3,
    e_subop_translation_switch = 3'd4,
    e_subop_context_switch     = 3'd5
  } bp_fe_command_queue_subopcodes_e;

  typedef enum logic [1:0] {
    e_not_a_branch          = 2'd0,
    e_incorrect_pred_taken  = 2'd1,
    e_incorrect_pred_ntaken = 2'd2
  } bp_fe_misprediction_reason_e;

  typedef struct packed {
    logic [vaddr_width_gp-1:0] src_vaddr;
    logic                      is_br;
    logic                      is_jal;
    logic                      is_jalr;
    logic                      is_call;
    logic                      is_ret;
    logic                      src_btb;
    logic                      src_ret;
  } bp_fe_branch_metadata_fwd_s;

  // Both operand views keep the metadata in the same MSB position.
  typedef struct packed {
    bp_fe_branch_metadata_fwd_s      branch_metadata_fwd;
    bp_fe_command_queue_subopcodes_e subopcode;
    bp_fe_misprediction_reason_e     misprediction_reason;
  } bp_fe_cmd_pc_redirect_operands_s;

  typedef struct packed {
    bp_fe_branch_metadata_fwd_s branch_metadata_fwd;
    logic                       taken;
    logic [3:0]                 padding;
  } bp_fe_cmd_attaboy_s;

  typedef union packed {
    bp_fe_cmd_pc_redirect_operands_s pc_redirect_operands;
    bp_fe_cmd_attaboy_s              attaboy;
  } bp_fe_cmd_operands_u;

  typedef struct packed {
    bp_fe_command_queue_opcodes_e opcode;
    logic [vaddr_width_gp-1:0]    vaddr;
    bp_fe_cmd_operands_u          operands;
  } bp_fe_cmd_s;

  function automatic int unsigned bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return vaddr_width_gp;
      default:          return vaddr_width_gp;
    endcase
  endfunction

  // stamp + src + dst + 3-bit type + mispred/taken/src_btb/src_ret
  function automatic int unsigned bp_branch_event_width(int unsigned vaddr_width,
                                                        int unsigned instr_cnt_width);
    return instr_cnt_width + 2 * vaddr_width + 3 + 4;
  endfunction

endpackage

// File: rtl/bp_branch_event_buffer_fifo.sv
// Small 1r1w FIFO with wrap-bit pointers; enqueue attempts while full are dropped and flagged.
module bp_branch_event_fifo #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_li,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  output logic               drop_o
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);
  localparam logic [ptr_width_lp:0] ptr_one_lp = {{ptr_width_lp{1'b0}}, 1'b1};

  logic [ptr_width_lp:0] rptr_q, wptr_q;
  logic [width_p-1:0]    mem_q [els_p];
  logic                  full, empty, enq, deq;

  assign empty = (rptr_q == wptr_q);
  assign full  = (rptr_q[ptr_width_lp-1:0] == wptr_q[ptr_width_lp-1:0])
              && (rptr_q[ptr_width_lp] != wptr_q[ptr_width_lp]);

  // Fullness is judged at cycle start, so a same-cycle dequeue cannot make room.
  assign enq    = v_i & ~full;
  assign deq    = yumi_i & ~empty;
  assign drop_o = v_i & full;

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      if (enq) wptr_q <= wptr_q + ptr_one_lp;
      if (deq) rptr_q <= rptr_q + ptr_one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[ptr_width_lp-1:0]] <= data_i;
  end

  assign v_o    = ~empty;
  assign data_o = empty ? '0 : mem_q[rptr_q[ptr_width_lp-1:0]];

endmodule

// File: rtl/bp_branch_event_buffer.sv
// Classifies accepted attaboys and mispredict redirects into stamped branch records and queues them.
// Optional drop counter / overflow flag enabled by defining BP_BRANCH_EVENT_DROP_CNT_EN.
module bp_branch_event_buffer
  import bp_branch_event_buffer_pkg::*;
#(
  parameter bp_params_e  bp_params_p       = e_bp_default_cfg,
  parameter int unsigned els_p             = 8,
  parameter int unsigned instr_cnt_width_p = 32,
  parameter int unsigned drop_cnt_width_p  = 16,
  localparam int unsigned vaddr_width_p    = bp_vaddr_width(bp_params_p),
  localparam int unsigned fe_cmd_width_lp  = $bits(bp_fe_cmd_s),
  localparam int unsigned bp_branch_event_width_lp =
    bp_branch_event_width(vaddr_width_p, instr_cnt_width_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_li,
  input  logic                                freeze_i,
  input  logic [fe_cmd_width_lp-1:0]          fe_cmd_i,
  input  logic                                fe_cmd_yumi_i,
  input  logic                                commit_v_i,
  output logic [bp_branch_event_width_lp-1:0] event_o,
  output logic                                event_v_o,
  input  logic                                event_yumi_i,
  output logic [instr_cnt_width_p-1:0]        instr_cnt_o,
  output logic [drop_cnt_width_p-1:0]         drop_cnt_o,
  output logic                                overflow_o
);

  typedef struct packed {
    logic [instr_cnt_width_p-1:0] instr;
    logic [vaddr_width_p-1:0]     src_vaddr;
    logic [vaddr_width_p-1:0]     dst_vaddr;
    bp_branch_type_e              br_type;
    logic                         mispred;
    logic                         taken;
    logic                         src_btb;
    logic                         src_ret;
  } bp_branch_event_s;

  bp_fe_cmd_s                   fe_cmd;
  bp_fe_branch_metadata_fwd_s   meta;
  bp_branch_event_s             rec;
  logic                         is_attaboy, is_mispredict, capture, drop;
  logic [instr_cnt_width_p-1:0] instr_cnt_q;

  assign fe_cmd = fe_cmd_i;

  always_comb begin
    is_attaboy    = (fe_cmd.opcode == e_op_attaboy);
    is_mispredict = (fe_cmd.opcode == e_op_pc_redirection)
                 && (fe_cmd.operands.pc_redirect_operands.subopcode == e_subop_branch_mispredict);
    meta          = is_attaboy ? fe_cmd.operands.attaboy.branch_metadata_fwd
                               : fe_cmd.operands.pc_redirect_operands.branch_metadata_fwd;
    capture       = fe_cmd_yumi_i & ~freeze_i & (is_attaboy | is_mispredict);

    rec           = '0;
    rec.instr     = instr_cnt_q;
    rec.src_vaddr = meta.src_vaddr;
    rec.dst_vaddr = fe_cmd.vaddr;
    rec.mispred   = ~is_attaboy;
    rec.taken     = is_attaboy ? fe_cmd.operands.attaboy.taken
                  : (fe_cmd.operands.pc_redirect_operands.misprediction_reason
                     == e_incorrect_pred_taken);
    rec.src_btb   = meta.src_btb;
    rec.src_ret   = meta.src_ret;
    if (meta.is_ret)       rec.br_type = e_br_type_ret;
    else if (meta.is_call) rec.br_type = e_br_type_call;
    else if (meta.is_jalr) rec.br_type = e_br_type_jalr;
    else if (meta.is_jal)  rec.br_type = e_br_type_jal;
    else if (meta.is_br)   rec.br_type = e_br_type_br;
    else                   rec.br_type = e_br_type_unknown;
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) instr_cnt_q <= '0;
    else           instr_cnt_q <= instr_cnt_q + instr_cnt_width_p'(commit_v_i & ~freeze_i);
  end

  assign instr_cnt_o = instr_cnt_q;

  bp_branch_event_fifo #(
    .width_p(bp_branch_event_width_lp),
    .els_p  (els_p)
  ) fifo (
    .clk_i   (clk_i),
    .reset_li(reset_li),
    .data_i  (rec),
    .v_i     (capture),
    .data_o  (event_o),
    .v_o     (event_v_o),
    .yumi_i  (event_yumi_i),
    .drop_o  (drop)
  );

`ifdef BP_BRANCH_EVENT_DROP_CNT_EN
  logic [drop_cnt_width_p-1:0] drop_cnt_q;
  logic                        overflow_q;

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (~&drop_cnt_q) drop_cnt_q <= drop_cnt_q + {{(drop_cnt_width_p-1){1'b0}}, 1'b1};
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_cnt_o  = '0;
  assign overflow_o  = 1'b0;
`endif

endmodule

// File: tb/tb_bp_branch_event_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_bp_branch_event_buffer;
  import bp_branch_event_buffer_pkg::*;

  localparam int unsigned Els = 8;
  localparam int unsigned EW  = bp_branch_event_width(39, 32);

  logic          clk = 1'b0;
  logic          reset_li;
  logic          freeze;
  bp_fe_cmd_s    fe_cmd;
  logic          fe_cmd_yumi;
  logic          commit_v;
  logic [EW-1:0] event_rec;
  logic          event_v;
  logic          event_yumi;
  logic [31:0]   instr_cnt;
  logic [15:0]   drop_cnt;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [EW-1:0] mq[$];
  logic [31:0]   m_cnt;
  logic [15:0]   m_drop;
  logic          m_ovf;

  bp_branch_event_buffer #(
    .els_p(Els)
  ) dut (
    .clk_i        (clk),
    .reset_li     (reset_li),
    .freeze_i     (freeze),
    .fe_cmd_i     (fe_cmd),
    .fe_cmd_yumi_i(fe_cmd_yumi),
    .commit_v_i   (commit_v),
    .event_o      (event_rec),
    .event_v_o    (event_v),
    .event_yumi_i (event_yumi),
    .instr_cnt_o  (instr_cnt),
    .drop_cnt_o   (drop_cnt),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  function automatic logic [EW-1:0] pack_rec(logic [31:0] stamp, logic [38:0] src, logic [38:0] dst,
                                             logic [2:0] ty, logic mis, logic tk, logic btb,
                                             logic ret);
    return {stamp, src, dst, ty, mis, tk, btb, ret};
  endfunction

  function automatic logic model_captures(bp_fe_cmd_s c, logic yumi, logic frz);
    logic relevant;
    relevant = (c.opcode == e_op_attaboy)
            || (c.opcode == e_op_pc_redirection
                && c.operands.pc_redirect_operands.subopcode == e_subop_branch_mispredict);
    return yumi && !frz && relevant;
  endfunction

  function automatic logic [EW-1:0] model_record(bp_fe_cmd_s c, logic [31:0] stamp);
    bp_fe_branch_metadata_fwd_s m;
    logic mis, tk;
    logic [2:0] ty;
    if (c.opcode == e_op_attaboy) begin
      m   = c.operands.attaboy.branch_metadata_fwd;
      mis = 1'b0;
      tk  = c.operands.attaboy.taken;
    end else begin
      m   = c.operands.pc_redirect_operands.branch_metadata_fwd;
      mis = 1'b1;
      tk  = (c.operands.pc_redirect_operands.misprediction_reason == e_incorrect_pred_taken);
    end
    ty = m.is_ret ? 3'd4 : m.is_call ? 3'd3 : m.is_jalr ? 3'd2 : m.is_jal ? 3'd1 :
         m.is_br ? 3'd0 : 3'd5;
    return pack_rec(stamp, m.src_vaddr, c.vaddr, ty, mis, tk, m.src_btb, m.src_ret);
  endfunction

  function automatic logic [15:0] exp_drop();
`ifdef BP_BRANCH_EVENT_DROP_CNT_EN
    return m_drop;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic exp_ovf();
`ifdef BP_BRANCH_EVENT_DROP_CNT_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bp_fe_branch_metadata_fwd_s mk_meta(logic [38:0] src, logic [6:0] flags);
    bp_fe_branch_metadata_fwd_s m;
    m = {src, flags};
    return m;
  endfunction

  function automatic bp_fe_cmd_s mk_attaboy(logic [38:0] va, logic tk,
                                            bp_fe_branch_metadata_fwd_s m);
    bp_fe_cmd_s c;
    c = '0;
    c.opcode = e_op_attaboy;
    c.vaddr = va;
    c.operands.attaboy.branch_metadata_fwd = m;
    c.operands.attaboy.taken = tk;
    return c;
  endfunction

  function automatic bp_fe_cmd_s mk_redirect(logic [38:0] va, bp_fe_command_queue_subopcodes_e sub,
                                             bp_fe_misprediction_reason_e rsn,
                                             bp_fe_branch_metadata_fwd_s m);
    bp_fe_cmd_s c;
    c = '0;
    c.opcode = e_op_pc_redirection;
    c.vaddr = va;
    c.operands.pc_redirect_operands.branch_metadata_fwd = m;
    c.operands.pc_redirect_operands.subopcode = sub;
    c.operands.pc_redirect_operands.misprediction_reason = rsn;
    return c;
  endfunction

  function automatic bp_fe_cmd_s rand_cmd();
    logic [63:0] r;
    bp_fe_cmd_s c;
    r = {$urandom, $urandom};
    c = r[$bits(bp_fe_cmd_s)-1:0];
    case ($urandom_range(0, 9))
      0, 1, 2, 3: c.opcode = e_op_attaboy;
      4, 5, 6:    c.opcode = e_op_pc_redirection;
      default:    c.opcode = bp_fe_command_queue_opcodes_e'(3'($urandom_range(0, 5)));
    endcase
    if (c.opcode == e_op_pc_redirection) begin
      c.operands.pc_redirect_operands.subopcode = ($urandom_range(0, 2) != 0)
        ? e_subop_branch_mispredict
        : bp_fe_command_queue_subopcodes_e'(3'($urandom_range(1, 5)));
      c.operands.pc_redirect_operands.misprediction_reason =
        bp_fe_misprediction_reason_e'(2'($urandom_range(0, 2)));
    end
    return c;
  endfunction

  task automatic idle();
    freeze = 1'b0; fe_cmd = '0; fe_cmd_yumi = 1'b0; commit_v = 1'b0; event_yumi = 1'b0;
  endtask

  // Advance one clock, apply the same inputs to the model, settle for sampling.
  task automatic tick();
    logic          cap, was_full;
    logic [EW-1:0] rec;
    @(posedge clk);
    cap      = model_captures(fe_cmd, fe_cmd_yumi, freeze);
    rec      = model_record(fe_cmd, m_cnt);
    was_full = (mq.size() == Els);
    if (event_yumi && mq.size() != 0) void'(mq.pop_front());
    if (cap) begin
      if (was_full) begin
        if (m_drop != 16'hffff) m_drop = m_drop + 16'd1;
        m_ovf = 1'b1;
      end else begin
        mq.push_back(rec);
      end
    end
    if (!freeze && commit_v) m_cnt = m_cnt + 32'd1;
    #1;
  endtask

  task automatic model_reset();
    mq.delete(); m_cnt = '0; m_drop = '0; m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    reset_li = 1'b0;
    idle();
    model_reset();
    #7;
    checks++; if (event_v !== 1'b0) begin errors++;
      $display("FAIL reset_v: got %0b want 0", event_v); end
    checks++; if (event_rec !== '0) begin errors++;
      $display("FAIL reset_event: got %h want 0", event_rec); end
    checks++; if (instr_cnt !== 32'd0) begin errors++;
      $display("FAIL reset_instr_cnt: got %0d want 0", instr_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++;
      $display("FAIL reset_overflow: got %0b want 0", overflow); end
    #5 reset_li = 1'b1;
    tick();
    checks++; if (event_v !== 1'b0 || instr_cnt !== 32'd0) begin errors++;
      $display("FAIL post_reset_idle: got v=%0b cnt=%0d want v=0 cnt=0", event_v, instr_cnt); end
  endtask

  task automatic test_first_attaboy();
    logic [EW-1:0] want;
    commit_v = 1'b1;
    repeat (3) tick();
    commit_v = 1'b0;
    fe_cmd = mk_attaboy(39'h0_8000_0010, 1'b1, mk_meta(39'h0_8000_0000, 7'b1000000));
    fe_cmd_yumi = 1'b1;
    tick();
    idle();
    want = pack_rec(32'd3, 39'h0_8000_0000, 39'h0_8000_0010, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (event_v !== 1'b1) begin errors++;
      $display("FAIL attaboy_v: got %0b want 1", event_v); end
    checks++; if (event_rec !== want) begin errors++;
      $display("FAIL attaboy_record: got %h want %h", event_rec, want); end
    checks++; if (instr_cnt !== 32'd3) begin errors++;
      $display("FAIL attaboy_instr_cnt: got %0d want 3", instr_cnt); end
    event_yumi = 1'b1;
    tick();
    idle();
    checks++; if (event_v !== 1'b0) begin errors++;
      $display("FAIL attaboy_drain: got v=%0b want 0", event_v); end
  endtask

  task automatic test_redirect_ret();
    fe_cmd = mk_redirect(39'h0_8000_0100, e_subop_branch_mispredict, e_incorrect_pred_taken,
                         mk_meta(39'h0_8000_0044, 7'b1000100));
    fe_cmd_yumi = 1'b1;
    tick();
    idle();
    checks++; if (event_v !== 1'b1) begin errors++;
      $display("FAIL redirect_v: got %0b want 1", event_v); end
    checks++; if (event_rec[6:0] !== {3'd4, 1'b1, 1'b1, 2'b00}) begin errors++;
      $display("FAIL redirect_fields: got %b want %b", event_rec[6:0], {3'd4, 4'b1100}); end
    checks++; if (event_rec !== (mq.size() != 0 ? mq[0] : '0)) begin errors++;
      $display("FAIL redirect_model: got %h want %h", event_rec, mq[0]); end
    event_yumi = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_no_capture();
    fe_cmd = mk_redirect(39'h12, e_subop_trap, e_incorrect_pred_taken, mk_meta(39'h34, 7'h7f));
    fe_cmd_yumi = 1'b1;
    tick();
    checks++; if (event_v !== 1'b0) begin errors++;
      $display("FAIL nocap_trap: got v=%0b want 0", event_v); end
    fe_cmd = mk_attaboy(39'h56, 1'b1, mk_meta(39'h78, 7'b1000000));
    fe_cmd_yumi = 1'b0;
    tick();
    checks++; if (event_v !== 1'b0) begin errors++;
      $display("FAIL nocap_no_yumi: got v=%0b want 0", event_v); end
    fe_cmd_yumi = 1'b1; freeze = 1'b1; commit_v = 1'b1;
    tick();
    checks++; if (event_v !== 1'b0 || instr_cnt !== 32'd3) begin errors++;
      $display("FAIL nocap_freeze: got v=%0b cnt=%0d want v=0 cnt=3", event_v, instr_cnt); end
    // Empty FIFO: consumer yumi is ignored and the capture lands.
    freeze = 1'b0; commit_v = 1'b0; event_yumi = 1'b1;
    tick();
    idle();
    checks++; if (event_v !== 1'b1 || event_rec !== mq[0]) begin errors++;
      $display("FAIL empty_yumi_capture: got v=%0b rec=%h want v=1 rec=%h", event_v, event_rec,
               mq[0]); end
    event_yumi = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] s0;
    s0 = m_cnt;
    for (int i = 0; i < 10; i++) begin
      fe_cmd = mk_attaboy(39'(i), 1'b0, mk_meta(39'(100 + i), 7'b0100000));
      fe_cmd_yumi = 1'b1; commit_v = 1'b1;
      tick();
    end
    idle();
    checks++; if (drop_cnt !== exp_drop()) begin errors++;
      $display("FAIL overflow_drop_cnt: got %0d want %0d", drop_cnt, exp_drop()); end
    checks++; if (overflow !== exp_ovf()) begin errors++;
      $display("FAIL overflow_flag: got %0b want %0b", overflow, exp_ovf()); end
`ifdef BP_BRANCH_EVENT_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd2 || overflow !== 1'b1) begin errors++;
      $display("FAIL overflow_const: got %0d/%0b want 2/1", drop_cnt, overflow); end
`else
    checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++;
      $display("FAIL overflow_const: got %0d/%0b want 0/0", drop_cnt, overflow); end
`endif
    for (int i = 0; i < 8; i++) begin
      checks++; if (event_v !== 1'b1 || event_rec[116:85] !== s0 + 32'(i)) begin errors++;
        $display("FAIL drain_stamp_%0d: got v=%0b stamp=%0d want v=1 stamp=%0d", i, event_v,
                 event_rec[116:85], s0 + 32'(i)); end
      event_yumi = 1'b1;
      tick();
    end
    idle();
    checks++; if (event_v !== 1'b0) begin errors++;
      $display("FAIL drain_empty: got v=%0b want 0", event_v); end
  endtask

  task automatic test_full_yumi();
    int n;
    for (int i = 0; i < 8; i++) begin
      fe_cmd = mk_redirect(39'(200 + i), e_subop_branch_mispredict, e_incorrect_pred_ntaken,
                           mk_meta(39'(i), 7'b0010000));
      fe_cmd_yumi = 1'b1;
      tick();
    end
    fe_cmd = mk_attaboy(39'h999, 1'b1, mk_meta(39'h111, 7'b0001000));
    event_yumi = 1'b1;
    tick();
    idle();
    checks++; if (event_rec !== mq[0] || event_rec[45:7] !== 39'd201) begin errors++;
      $display("FAIL full_yumi_head: got %h want %h", event_rec, mq[0]); end
    checks++; if (drop_cnt !== exp_drop()) begin errors++;
      $display("FAIL full_yumi_drop: got %0d want %0d", drop_cnt, exp_drop()); end
    n = 0;
    for (int i = 0; i < 12 && event_v; i++) begin
      event_yumi = 1'b1;
      tick();
      n++;
    end
    idle();
    checks++; if (n !== 7) begin errors++;
      $display("FAIL full_yumi_remaining: got %0d want 7", n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      freeze      = ($urandom_range(0, 9) == 0);
      fe_cmd      = rand_cmd();
      fe_cmd_yumi = ($urandom_range(0, 9) < 6);
      commit_v    = $urandom_range(0, 1) == 1;
      event_yumi  = (mq.size() != 0) && ($urandom_range(0, 9) < 4);
      tick();
      checks++; if (event_v !== (mq.size() != 0)) begin errors++;
        $display("FAIL rand_v[%0d]: got %0b want %0b", i, event_v, mq.size() != 0); end
      checks++; if (event_rec !== (mq.size() != 0 ? mq[0] : '0)) begin errors++;
        $display("FAIL rand_event[%0d]: got %h want %h", i, event_rec,
                 (mq.size() != 0 ? mq[0] : '0)); end
      checks++; if (instr_cnt !== m_cnt) begin errors++;
        $display("FAIL rand_instr_cnt[%0d]: got %0d want %0d", i, instr_cnt, m_cnt); end
      checks++; if (drop_cnt !== exp_drop() || overflow !== exp_ovf()) begin errors++;
        $display("FAIL rand_drop[%0d]: got %0d/%0b want %0d/%0b", i, drop_cnt, overflow,
                 exp_drop(), exp_ovf()); end
    end
    idle();
  endtask

  task automatic test_reset_midcycle();
    while (mq.size() != 0) begin
      event_yumi = 1'b1;
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      fe_cmd = mk_attaboy(39'(i), 1'b1, mk_meta(39'(i), 7'b1000000));
      fe_cmd_yumi = 1'b1; commit_v = 1'b1;
      tick();
    end
    idle();
    checks++; if (event_v !== 1'b1) begin errors++;
      $display("FAIL midreset_pre_v: got %0b want 1", event_v); end
    #2 reset_li = 1'b0;
    model_reset();
    #1;
    checks++; if (event_v !== 1'b0 || event_rec !== '0) begin errors++;
      $display("FAIL midreset_v: got v=%0b rec=%h want 0", event_v, event_rec); end
    checks++; if (instr_cnt !== 32'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++;
      $display("FAIL midreset_counters: got %0d/%0d/%0b want 0/0/0", instr_cnt, drop_cnt,
               overflow); end
    #3 reset_li = 1'b1;
    tick();
    checks++; if (event_v !== 1'b0 || instr_cnt !== 32'd0) begin errors++;
      $display("FAIL midreset_release: got v=%0b cnt=%0d want 0/0", event_v, instr_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_attaboy();
    test_redirect_ret();
    test_no_capture();
    test_overflow();
    test_full_yumi();
    test_random();
    test_reset_midcycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
